// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter: a small byte FIFO with a valid/ready write port
// feeds a start/data/stop serialiser with a programmable bit period.
module uart_tx #(
  parameter int DIVISOR = 286,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(DIVISOR);

  localparam logic [CNTW-1:0] FULL     = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] EMPTY    = CNTW'(0);
  localparam logic [CW-1:0]   DIV_LAST = CW'(DIVISOR - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic [1:0]      state;
  logic [CW-1:0]   div_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            push;
  logic            pop;
  logic            bit_end;
  logic            fifo_nonempty;

  assign ready = (count != FULL);
  assign busy  = (state != S_IDLE) || fifo_nonempty;

  // Handshake, bit-boundary and pop decode; pops only happen from IDLE or at the end of STOP.
  always_comb begin
    fifo_nonempty = (count != EMPTY);
    bit_end       = (div_cnt == DIV_LAST);
    push          = data_valid && ready;
    pop           = 1'b0;
    case (state)
      S_IDLE:  pop = fifo_nonempty;
      S_STOP:  pop = bit_end && fifo_nonempty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; no reset needed since entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers and occupancy; a write while full is dropped because ready gates push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= PW'(0);
      rd_ptr <= PW'(0);
      count  <= EMPTY;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialiser FSM; tx is registered and changes on the edge that starts each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= CW'(0);
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            div_cnt <= CW'(0);
            tx      <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            div_cnt <= CW'(0);
            bit_idx <= 3'd0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            div_cnt <= CW'(0);
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              tx <= shift[1];
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            div_cnt <= CW'(0);
            if (pop) begin
              // Chain straight into the next start bit with no idle cycle.
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= S_START;
            end else begin
              tx    <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          div_cnt <= CW'(0);
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the board's 115200 8-N-1 serial link, clocked from the 33 MHz LPC clock. Accepts bytes from host-side logic through a valid/ready handshake into a small FIFO, then serialises each byte onto `tx` LSB first, framed by one start bit and one stop bit. It is the counterpart of the existing UART receiver and uses the same bit-period divisor, so a `tx`→`rx` loopback is bit-exact.

## Interface
- `DIVISOR`, 286: clock cycles per bit (286 × 115200 ≈ 33 MHz); legal range ≥ 2.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `data`  in  8  byte to send; sampled only on an accepted write.
- `data_valid`  in  1  write request.
- `ready`  out  1  FIFO not full; write accepted on a rising edge with `data_valid && ready`.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high while FIFO is non-empty or a frame is in progress.

## Operation
- FIFO: `DEPTH` × 8 bits, read/write pointers of log2(`DEPTH`) bits that wrap modulo `DEPTH`, occupancy count of log2(`DEPTH`)+1 bits.
- `ready` = (count != `DEPTH`), combinational from count only. A write while full is dropped, even if a pop occurs on the same edge.
- Write and pop on the same edge: both take effect, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head into the shift register, clear the divisor counter, drive `tx`=0, and go to START.
  - START: hold `tx`=0 for `DIVISOR` cycles. Then drive `tx`=shift[0], clear the bit index, and go to DATA.
  - DATA: each bit is held `DIVISOR` cycles. At each bit end, shift right and increment the index. After bit 7 ends, drive `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for `DIVISOR` cycles. At the end, if the FIFO is non-empty, pop, drive `tx`=0 and go to START with no idle gap. Otherwise go to IDLE.
- Divisor counter: ceil(log2(`DIVISOR`)) bits (9 for 286). Counts 0..`DIVISOR`−1; reaching `DIVISOR`−1 marks the bit boundary, and the counter returns to 0.
- Bit index: 3 bits, 0..7.
- `busy` = (state != IDLE) || (count != 0).
- Reset (asserted at any time, including mid-frame): immediately forces `tx`=1, `ready`=1, `busy`=0, state IDLE, FIFO empty, pointers and counters 0. The aborted frame is not resumed. No frame starts after release until a new write is accepted.

## Timing
- Reset values: `tx`=1, `ready`=1, `busy`=0.
- Write accepted at edge N into an empty FIFO with the FSM in IDLE:
  - `busy` rises after edge N.
  - `tx` falls after edge N+1, so first-bit latency is 1 cycle after acceptance.
- Frame length is exactly 10 × `DIVISOR` = 2860 cycles.
  - Start bit: cycles N+1..N+286.
  - Data bit k: starts at N+1+286·(k+1).
  - Stop bit ends at N+2860.
- Back-to-back: the next start bit begins on the cycle immediately after the previous stop bit's last cycle.
- `ready` deasserts the cycle after the write that fills the FIFO, and reasserts the cycle after the next pop.
- `busy` falls after the edge ending the last stop bit when the FIFO is empty.

## Test plan
- Single byte: write 0x55 at edge 0 → `tx` low from cycle 1 for 286 cycles, then bits 1,0,1,0,1,0,1,0 at 286 cycles each, then stop high; `busy` low after cycle 2860.
- Back-to-back: write 0x00, 0xFF, 0xA5 on consecutive edges → three frames totalling 8580 cycles with no idle cycle between stop and start; the decoded bytes match in order.
- Overflow: hold `data_valid` high with bytes 0x10..0x15 on edges 0..5 from idle → 0x10..0x14 accepted; `ready`=0 at edge 5 and 0x15 is dropped. Exactly five frames are sent.
- FIFO pointer wrap: 12 writes, each issued as soon as `ready` is high → all 12 bytes transmitted in order.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0xC3 with 2 bytes queued → `tx`=1 and `busy`=0 immediately. After release there is no `tx` activity for ≥ 3000 cycles.
- Loopback: connect `tx` to the UART receiver and send 0x00, 0x7A, 0x80, 0xFF → the receiver pulses `data_valid` once per byte with matching `data`.
